// File: rtl/pixel_collector_pkg.sv
// Shared definitions for the pixel collector: pixel width and frame sizing helpers.
package pixel_collector_pkg;

    localparam int PIX_W = 4;

    typedef logic [PIX_W-1:0] pix_t;

    // Framebuffer entries are {addr, data}; address width comes from the instantiating block.
    function automatic int entry_width(input int addr_w);
        return addr_w + PIX_W;
    endfunction

    function automatic int frame_pixels(input int fb_width, input int fb_height);
        return fb_width * fb_height;
    endfunction

endpackage

// File: rtl/pixel_collector_lane_fifo.sv
// Per-lane synchronous FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module collector_lane_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               rd_ptr;
    logic [AW-1:0]               wr_ptr;
    logic [AW:0]                 count;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_collector.sv
// Collects row-interleaved solver results, tags them with framebuffer addresses and merges them
// round-robin into one write stream. Define PIXEL_COLLECTOR_COUNT_EN to add the pixels_written counter.
module pixel_collector
    import pixel_collector_pkg::*;
#(
    parameter int NUM_SOLVERS = 4,
    parameter int FB_WIDTH    = 640,
    parameter int FB_HEIGHT   = 480,
    parameter int ADDR_W      = 19,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_SOLVERS-1:0]       sol_ready,
    input  logic [PIX_W*NUM_SOLVERS-1:0] sol_data,
    input  logic [NUM_SOLVERS-1:0]       sol_done,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [PIX_W-1:0]             wr_data,
    output logic                         frame_done,
    output logic                         overflow,
    output logic                         range_err
`ifdef PIXEL_COLLECTOR_COUNT_EN
    ,
    output logic [ADDR_W:0]              pixels_written
`endif
);
    localparam int LW    = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
    localparam int COL_W = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
    localparam int ROW_W = $clog2(FB_HEIGHT + NUM_SOLVERS) + 1;
    localparam int ENT_W = entry_width(ADDR_W);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        pix_t              data;
    } entry_t;

    logic [NUM_SOLVERS-1:0]             rdy_q;
    logic [NUM_SOLVERS-1:0][PIX_W-1:0]  data_q;
    logic [NUM_SOLVERS-1:0]             in_range;
    logic [NUM_SOLVERS-1:0]             push;
    logic [NUM_SOLVERS-1:0]             pop;
    logic [NUM_SOLVERS-1:0]             full;
    logic [NUM_SOLVERS-1:0]             empty;
    logic [NUM_SOLVERS-1:0][ENT_W-1:0]  push_ent;
    logic [NUM_SOLVERS-1:0][ENT_W-1:0]  head;
    logic [LW-1:0]                      rr;
    logic [LW-1:0]                      grant_idx;
    logic                               grant_vld;
    logic                               load;
    logic                               base_ready;
    logic                               frame_ready;
    entry_t                             head_sel;

    // Capture stage: results are registered before they touch the lane counters.
    always_ff @(posedge clock) begin
        if (reset || start) begin
            rdy_q  <= '0;
            data_q <= '0;
        end else begin
            rdy_q  <= sol_ready;
            data_q <= sol_data;
        end
    end

    for (genvar k = 0; k < NUM_SOLVERS; k++) begin : g_lane
        localparam logic [ROW_W-1:0]  ROW0  = ROW_W'(k);
        localparam logic [ADDR_W-1:0] BASE0 = ADDR_W'(k * FB_WIDTH);

        logic [COL_W-1:0]  col;
        logic [ROW_W-1:0]  row;
        logic [ADDR_W-1:0] base;

        assign in_range[k] = (row < ROW_W'(FB_HEIGHT));
        assign push[k]     = rdy_q[k] && in_range[k];
        assign push_ent[k] = {base + ADDR_W'(col), data_q[k]};

        // base is a running row*FB_WIDTH so no multiplier sits in the address path.
        always_ff @(posedge clock) begin
            if (reset || start) begin
                col  <= '0;
                row  <= ROW0;
                base <= BASE0;
            end else if (push[k]) begin
                if (col == COL_W'(FB_WIDTH - 1)) begin
                    col  <= '0;
                    row  <= row + ROW_W'(NUM_SOLVERS);
                    base <= base + ADDR_W'(NUM_SOLVERS * FB_WIDTH);
                end else begin
                    col <= col + 1'b1;
                end
            end
        end

        collector_lane_fifo #(
            .WIDTH (ENT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .clear     (start),
            .push      (push[k]),
            .push_data (push_ent[k]),
            .pop       (pop[k]),
            .head      (head[k]),
            .full      (full[k]),
            .empty     (empty[k])
        );
    end

    always_comb begin
        int          j;
        logic [LW-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        j         = 0;
        idx       = '0;
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            j = int'(rr) + i;
            if (j >= NUM_SOLVERS) begin
                j = j - NUM_SOLVERS;
            end
            idx = LW'(j);
            if (!grant_vld && !empty[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign load     = grant_vld && (!wr_valid || wr_ready);
    assign head_sel = entry_t'(head[grant_idx]);

    always_comb begin
        pop = '0;
        if (load) begin
            pop[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || start) begin
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rr       <= '0;
        end else if (load) begin
            wr_valid <= 1'b1;
            wr_addr  <= head_sel.addr;
            wr_data  <= head_sel.data;
            rr       <= (grant_idx == LW'(NUM_SOLVERS - 1)) ? '0 : grant_idx + 1'b1;
        end else if (wr_ready) begin
            wr_valid <= 1'b0;
        end
    end

    // Pending captures count as outstanding work so frame_done cannot fire under them.
    assign base_ready = (&sol_done) && (&empty) && !wr_valid && !(|rdy_q);

`ifdef PIXEL_COLLECTOR_COUNT_EN
    localparam int FRAME_PIXELS = frame_pixels(FB_WIDTH, FB_HEIGHT);

    always_ff @(posedge clock) begin
        if (reset || start) begin
            pixels_written <= '0;
        end else if (wr_valid && wr_ready) begin
            pixels_written <= pixels_written + 1'b1;
        end
    end

    assign frame_ready = base_ready && (pixels_written == (ADDR_W+1)'(FRAME_PIXELS));
`else
    assign frame_ready = base_ready;
`endif

    always_ff @(posedge clock) begin
        if (reset || start) begin
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            if (frame_ready) begin
                frame_done <= 1'b1;
            end
            if (|(push & full & ~pop)) begin
                overflow <= 1'b1;
            end
            if (|(rdy_q & ~in_range)) begin
                range_err <= 1'b1;
            end
        end
    end

endmodule
